// File: rtl/vpu_issue_ctrl_pkg.sv
// Shared VPU types: FU selector, LMUL encoding, decoded uOP layout, group-mask helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vpu_issue_ctrl_pkg;

    localparam int NUM_FU_TYPES = 4;
    localparam int NUM_VREGS    = 32;

    // Functional unit targeted by a uOP; value doubles as the issue-port index.
    typedef enum logic [1:0] {
        FU_VALU = 2'd0,
        FU_VMUL = 2'd1,
        FU_VLSU = 2'd2,
        FU_VCFG = 2'd3
    } FU_e;

    // RVV vlmul encoding; fractional settings occupy a single register.
    typedef enum logic [2:0] {
        LMUL_1    = 3'd0,
        LMUL_2    = 3'd1,
        LMUL_4    = 3'd2,
        LMUL_8    = 3'd3,
        LMUL_RSVD = 3'd4,
        LMUL_F8   = 3'd5,
        LMUL_F4   = 3'd6,
        LMUL_F2   = 3'd7
    } VLMUL_e;

    // One vector register operand: vreg=0 means the slot is unused.
    typedef struct packed {
        logic       vreg;
        logic [4:0] addr;
    } vop_t;

    // Decoded uOP; op is an opaque payload carried through to the FU.
    typedef struct packed {
        FU_e        fu;
        VLMUL_e     vlmul;
        vop_t       rd;
        vop_t       rs1;
        vop_t       rs2;
        logic [7:0] op;
    } VPU_uOP_t;

    // Registers touched by an operand group: emul consecutive regs from addr,
    // anything past v31 simply falls off the top of the 32-bit mask.
    function automatic logic [NUM_VREGS-1:0] vreg_group_mask(
        input logic       vreg,
        input logic [4:0] addr,
        input VLMUL_e     vlmul
    );
        logic [NUM_VREGS-1:0] ones;
        case (vlmul)
            LMUL_2:  ones = 32'h0000_0003;
            LMUL_4:  ones = 32'h0000_000F;
            LMUL_8:  ones = 32'h0000_00FF;
            default: ones = 32'h0000_0001;
        endcase
        if (!vreg) begin
            return '0;
        end
        return ones << addr;
    endfunction

endpackage

// File: rtl/vpu_issue_ctrl_if.sv
// Decode-side and FU-side handshake bundle of the VPU issue controller.
// Latency: n/a (wires only).
// Backpressure: decode_ack_o toward decode, issue_ready_i from each FU.
interface vpu_issue_ctrl_if
    import vpu_issue_ctrl_pkg::*;
#(
    parameter int NUM_FU = 4
);
    logic              decode_entry_valid_i;
    VPU_uOP_t          decode_entry_i;
    logic              decode_ack_o;
    logic [NUM_FU-1:0] issue_valid_o;
    VPU_uOP_t          issue_uop_o;
    logic [NUM_FU-1:0] issue_ready_i;
    logic [NUM_FU-1:0] fu_done_i;
    logic              idle_o;

    // master: the issue controller itself.
    modport master (
        input  decode_entry_valid_i,
        input  decode_entry_i,
        output decode_ack_o,
        output issue_valid_o,
        output issue_uop_o,
        input  issue_ready_i,
        input  fu_done_i,
        output idle_o
    );

    // slave: decode buffer plus functional units around it.
    modport slave (
        output decode_entry_valid_i,
        output decode_entry_i,
        input  decode_ack_o,
        input  issue_valid_o,
        input  issue_uop_o,
        output issue_ready_i,
        output fu_done_i,
        input  idle_o
    );
endinterface

// File: rtl/vpu_uop_fifo.sv
// Circular uOP queue with read/write pointers and an occupancy count.
// Latency: a push in cycle N is visible at head_o in cycle N+1.
// Backpressure: full_o refuses pushes, even when a pop happens the same cycle.
module vpu_uop_fifo
    import vpu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push_i,
    input  VPU_uOP_t push_dat_i,
    input  logic     pop_i,
    output VPU_uOP_t head_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    VPU_uOP_t        mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Storage array: payload only, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks push minus pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/vpu_issue_ctrl.sv
// In-order VPU issue: queue decoded uOPs, scoreboard vregs per FU, offer head to its FU.
// Latency: accept in N -> earliest issue in N+1; done in N -> dependent issue in N+1.
// Backpressure: decode_ack_o low while queue full; offer held stable until FU ready.
module vpu_issue_ctrl
    import vpu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NUM_FU = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    vpu_issue_ctrl_if.master bus
);
    VPU_uOP_t                       head_uop;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           push;
    logic                           pop;

    logic [NUM_FU-1:0]              fu_busy_q;
    logic [NUM_FU-1:0][31:0]        fu_mask_q;
    logic [31:0]                    busy_regs;

    logic [31:0]                    rd_mask;
    logic [31:0]                    head_mask;
    logic                           hazard;
    logic                           head_ok;
    logic [NUM_FU-1:0]              issue_valid;

    assign push = bus.decode_entry_valid_i & ~fifo_full;
    assign pop  = |(issue_valid & bus.issue_ready_i);

    vpu_uop_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_dat_i (bus.decode_entry_i),
        .pop_i      (pop),
        .head_o     (head_uop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Union of every register group still being written by an outstanding uOP.
    always_comb begin
        busy_regs = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            busy_regs = busy_regs | fu_mask_q[f];
        end
    end

    // Head issue decision; depends only on registered state so the offer stays stable.
    // A config op waits for every FU to drain, and while it is outstanding nothing
    // younger may issue, since every later op depends on the new vector config.
    always_comb begin
        rd_mask   = vreg_group_mask(head_uop.rd.vreg, head_uop.rd.addr, head_uop.vlmul);
        head_mask = rd_mask
                  | vreg_group_mask(head_uop.rs1.vreg, head_uop.rs1.addr, head_uop.vlmul)
                  | vreg_group_mask(head_uop.rs2.vreg, head_uop.rs2.addr, head_uop.vlmul);
        hazard    = |(head_mask & busy_regs);
        head_ok   = ~fifo_empty & ~fu_busy_q[head_uop.fu] & ~hazard
                  & ~fu_busy_q[FU_VCFG];
        if (head_uop.fu == FU_VCFG) begin
            head_ok = head_ok & ~(|fu_busy_q);
        end
        issue_valid = '0;
        if (head_ok) begin
            issue_valid[head_uop.fu] = 1'b1;
        end
    end

    // Scoreboard: issue marks the FU busy with its destination group, done releases it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fu_busy_q <= '0;
            fu_mask_q <= '0;
        end else begin
            for (int f = 0; f < NUM_FU; f++) begin
                if (bus.fu_done_i[f] && fu_busy_q[f]) begin
                    fu_busy_q[f] <= 1'b0;
                    fu_mask_q[f] <= '0;
                end
                if (issue_valid[f] && bus.issue_ready_i[f]) begin
                    fu_busy_q[f] <= 1'b1;
                    fu_mask_q[f] <= (head_uop.fu == FU_VCFG) ? '0 : rd_mask;
                end
            end
        end
    end

    assign bus.decode_ack_o  = ~fifo_full;
    assign bus.issue_valid_o = issue_valid;
    assign bus.issue_uop_o   = fifo_empty ? '0 : head_uop;
    assign bus.idle_o        = fifo_empty & ~(|fu_busy_q);
endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Directed bench for vpu_issue_ctrl: hazards, full queue, config serialization, stall, reset.
// Latency: inputs driven 1ns after each rising edge, outputs checked at the same point.
// Backpressure: FU ready/done are driven directly by the step sequence.
module tb_vpu_issue_ctrl;
    import vpu_issue_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    vpu_issue_ctrl_if #(.NUM_FU(4)) bus ();

    vpu_issue_ctrl #(
        .DEPTH  (4),
        .NUM_FU (4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic VPU_uOP_t mk(input FU_e fu, input VLMUL_e lm,
                                    input logic rdv, input logic [4:0] rd,
                                    input logic s1v, input logic [4:0] s1,
                                    input logic s2v, input logic [4:0] s2,
                                    input logic [7:0] op);
        VPU_uOP_t u;
        u.fu = fu; u.vlmul = lm;
        u.rd.vreg = rdv;  u.rd.addr = rd;
        u.rs1.vreg = s1v; u.rs1.addr = s1;
        u.rs2.vreg = s2v; u.rs2.addr = s2;
        u.op = op;
        return u;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    VPU_uOP_t u;

    initial begin
        n_cmp = 0; n_err = 0;
        clk = 1'b0; rst = 1'b1;
        bus.decode_entry_valid_i = 1'b0;
        bus.decode_entry_i = '0;
        bus.issue_ready_i = '0;
        bus.fu_done_i = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_idle",  64'(bus.idle_o), 64'd1);
        chk("rst_ack",   64'(bus.decode_ack_o), 64'd1);
        chk("rst_valid", 64'(bus.issue_valid_o), 64'd0);
        chk("rst_uop",   64'(bus.issue_uop_o), 64'd0);

        // VALU v4 <- v1,v2 issues the cycle after accept
        u = mk(FU_VALU, LMUL_1, 1, 5'd4, 1, 5'd1, 1, 5'd2, 8'd1);
        bus.decode_entry_i = u; bus.decode_entry_valid_i = 1'b1; bus.issue_ready_i = 4'hF;
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t1_valid", 64'(bus.issue_valid_o), 64'h1);
        chk("t1_uop",   64'(bus.issue_uop_o), 64'(u));
        step();
        chk("t1_after_issue", 64'(bus.issue_valid_o), 64'h0);
        chk("t1_not_idle",    64'(bus.idle_o), 64'd0);
        // VMUL reading v4 must wait for VALU done
        bus.decode_entry_i = mk(FU_VMUL, LMUL_1, 1, 5'd5, 1, 5'd4, 0, 5'd0, 8'd2);
        bus.decode_entry_valid_i = 1'b1;
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t1_raw_stall0", 64'(bus.issue_valid_o), 64'h0);
        step();
        chk("t1_raw_stall1", 64'(bus.issue_valid_o), 64'h0);
        bus.fu_done_i = 4'b0001; step(); bus.fu_done_i = '0;
        chk("t1_unblock", 64'(bus.issue_valid_o), 64'h2);
        chk("t1_unblock_op", 64'(bus.issue_uop_o.op), 64'd2);
        step();
        bus.fu_done_i = 4'b0010; step(); bus.fu_done_i = '0;
        chk("t1_idle", 64'(bus.idle_o), 64'd1);

        // VALU writes v8..v11 (M4); VMUL reading v10 stalls until after done
        bus.decode_entry_i = mk(FU_VALU, LMUL_4, 1, 5'd8, 0, 5'd0, 0, 5'd0, 8'd3);
        bus.decode_entry_valid_i = 1'b1;
        step();
        bus.decode_entry_i = mk(FU_VMUL, LMUL_1, 1, 5'd20, 1, 5'd10, 0, 5'd0, 8'd4);
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t2_v10_stall0", 64'(bus.issue_valid_o), 64'h0);
        step();
        chk("t2_v10_stall1", 64'(bus.issue_valid_o), 64'h0);
        bus.fu_done_i = 4'b0001; step(); bus.fu_done_i = '0;
        chk("t2_v10_go", 64'(bus.issue_valid_o), 64'h2);
        chk("t2_v10_op", 64'(bus.issue_uop_o.op), 64'd4);
        step();
        bus.fu_done_i = 4'b0010; step(); bus.fu_done_i = '0;
        // VMUL reading v12 does not overlap v8..v11
        bus.decode_entry_i = mk(FU_VALU, LMUL_4, 1, 5'd8, 0, 5'd0, 0, 5'd0, 8'd5);
        bus.decode_entry_valid_i = 1'b1;
        step();
        bus.decode_entry_i = mk(FU_VMUL, LMUL_1, 1, 5'd13, 1, 5'd12, 0, 5'd0, 8'd6);
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t2_v12_go", 64'(bus.issue_valid_o), 64'h2);
        chk("t2_v12_op", 64'(bus.issue_uop_o.op), 64'd6);
        step();
        bus.fu_done_i = 4'b0011; step(); bus.fu_done_i = '0;
        chk("t2_idle", 64'(bus.idle_o), 64'd1);

        // Busy VLSU, then fill the queue with four VLSU ops
        bus.decode_entry_i = mk(FU_VLSU, LMUL_1, 1, 5'd16, 0, 5'd0, 0, 5'd0, 8'd7);
        bus.decode_entry_valid_i = 1'b1;
        step(); bus.decode_entry_valid_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            bus.decode_entry_i = mk(FU_VLSU, LMUL_1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 8'(8 + i));
            bus.decode_entry_valid_i = 1'b1;
            step();
        end
        chk("t3_full_ack", 64'(bus.decode_ack_o), 64'd0);
        chk("t3_full_valid", 64'(bus.issue_valid_o), 64'h0);
        bus.decode_entry_i = mk(FU_VLSU, LMUL_1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 8'd12);
        step();
        chk("t3_refused_ack", 64'(bus.decode_ack_o), 64'd0);
        bus.fu_done_i = 4'b0100; step(); bus.fu_done_i = '0;
        chk("t3_head_valid", 64'(bus.issue_valid_o), 64'h4);
        chk("t3_head_op", 64'(bus.issue_uop_o.op), 64'd8);
        step();
        chk("t3_nobypass_ack", 64'(bus.decode_ack_o), 64'd1);
        chk("t3_pop_valid", 64'(bus.issue_valid_o), 64'h0);
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t3_refill_ack", 64'(bus.decode_ack_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            bus.fu_done_i = 4'b0100; step(); bus.fu_done_i = '0;
            chk("t3_drain_valid", 64'(bus.issue_valid_o), 64'h4);
            chk("t3_drain_op", 64'(bus.issue_uop_o.op), 64'(9 + i));
            step();
        end
        bus.fu_done_i = 4'b0100; step(); bus.fu_done_i = '0;
        chk("t3_idle", 64'(bus.idle_o), 64'd1);

        // VCFG waits for all FUs idle, then blocks the younger VALU
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd1, 0, 5'd0, 0, 5'd0, 8'd20);
        bus.decode_entry_valid_i = 1'b1;
        step();
        bus.decode_entry_i = mk(FU_VCFG, LMUL_1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 8'd21);
        step();
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd2, 0, 5'd0, 0, 5'd0, 8'd22);
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t4_cfg_wait0", 64'(bus.issue_valid_o), 64'h0);
        step();
        chk("t4_cfg_wait1", 64'(bus.issue_valid_o), 64'h0);
        bus.fu_done_i = 4'b0001; step(); bus.fu_done_i = '0;
        chk("t4_cfg_valid", 64'(bus.issue_valid_o), 64'h8);
        chk("t4_cfg_op", 64'(bus.issue_uop_o.op), 64'd21);
        step();
        chk("t4_valu_wait0", 64'(bus.issue_valid_o), 64'h0);
        step();
        chk("t4_valu_wait1", 64'(bus.issue_valid_o), 64'h0);
        bus.fu_done_i = 4'b1000; step(); bus.fu_done_i = '0;
        chk("t4_valu_go", 64'(bus.issue_valid_o), 64'h1);
        chk("t4_valu_op", 64'(bus.issue_uop_o.op), 64'd22);
        step();
        bus.fu_done_i = 4'b0001; step(); bus.fu_done_i = '0;
        chk("t4_idle", 64'(bus.idle_o), 64'd1);

        // FU not ready for 3 cycles: offer must hold
        bus.issue_ready_i = 4'h0;
        u = mk(FU_VMUL, LMUL_2, 1, 5'd3, 1, 5'd6, 0, 5'd0, 8'd30);
        bus.decode_entry_i = u; bus.decode_entry_valid_i = 1'b1;
        step(); bus.decode_entry_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t5_hold_valid", 64'(bus.issue_valid_o), 64'h2);
            chk("t5_hold_uop", 64'(bus.issue_uop_o), 64'(u));
            step();
        end
        bus.issue_ready_i = 4'hF;
        chk("t5_ready_valid", 64'(bus.issue_valid_o), 64'h2);
        step();
        chk("t5_popped", 64'(bus.issue_valid_o), 64'h0);
        chk("t5_busy", 64'(bus.idle_o), 64'd0);
        bus.fu_done_i = 4'b0010; step(); bus.fu_done_i = '0;

        // Reset with 3 queued and 2 busy FUs
        bus.decode_entry_valid_i = 1'b1;
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd6, 0, 5'd0, 0, 5'd0, 8'd40); step();
        bus.decode_entry_i = mk(FU_VMUL, LMUL_1, 1, 5'd7, 0, 5'd0, 0, 5'd0, 8'd41); step();
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd9, 0, 5'd0, 0, 5'd0, 8'd42); step();
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd10, 0, 5'd0, 0, 5'd0, 8'd43); step();
        bus.decode_entry_i = mk(FU_VMUL, LMUL_1, 1, 5'd11, 0, 5'd0, 0, 5'd0, 8'd44); step();
        bus.decode_entry_valid_i = 1'b0;
        chk("t6_pre_idle", 64'(bus.idle_o), 64'd0);
        chk("t6_pre_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("t6_pre_ack", 64'(bus.decode_ack_o), 64'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_rst_idle", 64'(bus.idle_o), 64'd1);
        chk("t6_rst_valid", 64'(bus.issue_valid_o), 64'h0);
        chk("t6_rst_ack", 64'(bus.decode_ack_o), 64'd1);
        chk("t6_rst_uop", 64'(bus.issue_uop_o), 64'd0);
        bus.decode_entry_i = mk(FU_VALU, LMUL_1, 1, 5'd6, 0, 5'd0, 0, 5'd0, 8'd50);
        bus.decode_entry_valid_i = 1'b1;
        step(); bus.decode_entry_valid_i = 1'b0;
        chk("t6_post_valid", 64'(bus.issue_valid_o), 64'h1);
        chk("t6_post_op", 64'(bus.issue_uop_o.op), 64'd50);
        step();
        bus.fu_done_i = 4'b0001; step(); bus.fu_done_i = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/vpu_issue_ctrl.md
# vpu_issue_ctrl

In-order issue scheduler between the VPU decode buffer and the vector functional units (VALU, VMUL, VLSU, VCFG). It buffers decoded uOPs in a small FIFO, checks the head against a per-FU vector-register scoreboard, and issues one uOP per cycle to its target FU over a valid/ready handshake. Config ops are serialized: they issue only when every FU is idle.

## Interface
- DEPTH, 4, uOP queue entries; power of two, ≥2
- NUM_FU, 4, number of FU issue ports; equals the FU_e enum size
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- decode_entry_valid_i  in  1  decode buffer holds a uOP
- decode_entry_i  in  VPU_uOP_t  decoded uOP
- decode_ack_o  out  1  uOP accepted this cycle when valid
- issue_valid_o  out  NUM_FU  one-hot; head uOP offered to FU[f]
- issue_uop_o  out  VPU_uOP_t  head uOP, shared by all ports
- issue_ready_i  in  NUM_FU  FU[f] accepts the offered uOP
- fu_done_i  in  NUM_FU  FU[f] retired its outstanding uOP
- idle_o  out  1  queue empty and no FU busy

## Operation
- uOP fields used: fu (FU_e: VALU=0, VMUL=1, VLSU=2, VCFG=3), vlmul, and rd/rs1/rs2, each {vreg, addr[4:0]}.
- Queue: circular FIFO with rd/wr pointers plus a count. decode_ack_o = ~full. No bypass: a push into a full queue is refused even if the head pops in the same cycle.
- Register group mask of operand x: zero if ~x.vreg. Otherwise ((1<<emul)-1) << x.addr, truncated to 32 bits. emul = 1, 2, 4 or 8 for vlmul = M1, M2, M4, M8; fractional LMUL gives 1.
- Scoreboard: per FU, fu_busy_q[f] and fu_mask_q[f][31:0] (rd group of the outstanding uOP). busy_regs = OR of all fu_mask_q.
- Head issue condition, for f = head.fu: queue non-empty, ~fu_busy_q[f], and (mask(rs1)|mask(rs2)|mask(rd)) & busy_regs == 0.
- VCFG head: additionally requires all fu_busy_q == 0.
- issue_valid_o[f] = condition; other bits 0. The condition is a function of registered state only.
- Issue handshake: issue_valid_o[f] & issue_ready_i[f] pops the head, sets fu_busy_q[f], and loads fu_mask_q[f] = mask(rd). VCFG also marks its FU busy with mask 0.
- fu_done_i[f] clears fu_busy_q[f] and fu_mask_q[f]. fu_done_i on an idle FU is ignored.
- Each FU holds at most one outstanding uOP. Issue is strictly in order: a stalled head blocks all younger uOPs.
- Once asserted, issue_valid_o stays high with a stable issue_uop_o until ready, because nothing that feeds the condition can change while it waits.

## Timing
- Reset values: queue empty, all fu_busy_q/fu_mask_q = 0, decode_ack_o = 1, issue_valid_o = 0, idle_o = 1, issue_uop_o = 0.
- uOP accepted in cycle N appears at the head and can issue at the earliest in N+1.
- Throughput: 1 issue per cycle across FUs; 1 issue per FU per done.
- A done in cycle N unblocks the FU and its hazard no earlier than N+1, so back-to-back ops on the same FU have ≥1 idle cycle.
- Push and pop in the same cycle: count unchanged, both pointers advance, and both wrap at DEPTH.
- Push when full: no accept. Pop when empty: impossible, since valid is 0.
- Reset mid-operation drops all queued and outstanding state. FUs are reset by the same rst_i.

## Structure
- Shared VPU package holds FU_e, VPU_uOP_t, VLMUL_e and a function vreg_group_mask(vreg, addr, vlmul).
- Sub-module vpu_uop_fifo (parameter DEPTH) holds the queue: push/pop/full/empty/head. The scoreboard and issue logic stay at top level.

## Test plan
- Reset, then push VALU vd=v4 (M1), vs1=v1, vs2=v2 with ready=1 -> issue_valid_o=0001 one cycle after accept; v4 then busy until fu_done_i[0].
- VALU writes v8 (M4, mask 0x00000F00), then a VMUL reads v10 -> VMUL stalls until the cycle after fu_done_i[0]. A VMUL reading v12 instead issues immediately.
- Fill 4 uOPs all targeting a busy VLSU -> decode_ack_o=0 at count 4. Assert done -> one pop, and ack=1 the next cycle.
- VALU outstanding, then VCFG at head -> no issue until all FUs are idle. The VCFG then issues with issue_valid_o=1000, and the following VALU waits for fu_done_i[3].
- Hold issue_ready_i=0 for 3 cycles -> issue_valid_o and issue_uop_o are stable throughout, and the pop happens on the ready cycle.
- Assert rst_i with 3 queued uOPs and 2 busy FUs -> next cycle idle_o=1, issue_valid_o=0, decode_ack_o=1.
